sign_pipe: RTL and testbench

Pipelined, multi-channel successor to the combinational sign inverter. It applies a per-transfer sign operation to CHANNELS two's-complement words: pass, negate, absolute value, or negative absolute value. The most-negative input is handled explicitly, with optional saturation and a per-lane overflow flag. It sits on valid/ready streams between arithmetic stages of the interpolator datapath, has fixed latency 2, and sustains one transfer per cycle.

---
 rtl/sign_pipe_pkg.sv | 11 +
 rtl/sign_pipe_lane.sv | 46 ++++
 rtl/sign_pipe.sv | 87 ++++++++
 tb/tb_sign_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_pipe_pkg.sv
// Shared definitions for the sign_pipe datapath: per-transfer sign operation encoding.
package sign_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_NABS = 2'b11
    } mode_t;

endpackage

// File: rtl/sign_pipe_lane.sv
// One combinational lane: applies the sign operation at DATA_WIDTH+1 bits so that
// -MIN is representable, then folds the single overflow case back into range.
module sign_lane
    import sign_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter bit SATURATE   = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  mode_t                 mode,
    output logic [DATA_WIDTH-1:0] r,
    output logic                  ovf
);

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH:0] x_ext;
    logic signed [DATA_WIDTH:0] r_ext;
    logic                       x_neg;
    logic                       x_pos;

    always_comb begin
        x_ext = signed'({x[DATA_WIDTH-1], x});
        x_neg = x[DATA_WIDTH-1];
        x_pos = !x[DATA_WIDTH-1] && (x != '0);
        r_ext = x_ext;
        case (mode)
            MODE_PASS: r_ext = x_ext;
            MODE_NEG:  r_ext = -x_ext;
            MODE_ABS:  r_ext = x_neg ? -x_ext : x_ext;
            MODE_NABS: r_ext = x_pos ? -x_ext : x_ext;
            default:   r_ext = x_ext;
        endcase

        // Result no longer fits in DATA_WIDTH bits only when it equals +2^(DATA_WIDTH-1).
        ovf = r_ext[DATA_WIDTH] ^ r_ext[DATA_WIDTH-1];

        if (ovf) begin
            r = SATURATE ? MAX_VAL : MIN_VAL;
        end else begin
            r = r_ext[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sign_pipe.sv
// Two-stage valid/ready sign pipeline: S1 captures the input word and mode, S2 holds
// the per-lane results and overflow flags. Capacity two words, one transfer per cycle.
module sign_pipe
    import sign_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int CHANNELS   = 1,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
    input  logic [1:0]                     mode_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
    output logic [CHANNELS-1:0]            ovf_o,
    output logic                           valid_o,
    input  logic                           ready_i
);

    localparam int BUS_W = CHANNELS * DATA_WIDTH;

    logic              v1;
    logic [BUS_W-1:0]  d1;
    mode_t             m1;

    logic              v2;
    logic [BUS_W-1:0]  d2;
    logic [CHANNELS-1:0] ovf2;

    logic              adv1;
    logic              adv2;

    logic [BUS_W-1:0]    lane_r;
    logic [CHANNELS-1:0] lane_ovf;

    // A stage may load when it is empty or when the stage after it is draining.
    assign adv2    = !v2 || ready_i;
    assign adv1    = !v1 || adv2;
    assign ready_o = adv1;

    assign data_o  = d2;
    assign ovf_o   = ovf2;
    assign valid_o = v2;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        sign_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SATURATE   (SATURATE)
        ) u_lane (
            .x    (d1[k*DATA_WIDTH +: DATA_WIDTH]),
            .mode (m1),
            .r    (lane_r[k*DATA_WIDTH +: DATA_WIDTH]),
            .ovf  (lane_ovf[k])
        );
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1 <= 1'b0;
            d1 <= '0;
            m1 <= MODE_PASS;
        end else if (adv1) begin
            v1 <= valid_i;
            if (valid_i) begin
                d1 <= data_i;
                m1 <= mode_t'(mode_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v2   <= 1'b0;
            d2   <= '0;
            ovf2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                d2   <= lane_r;
                ovf2 <= lane_ovf;
            end
        end
    end

endmodule

// File: tb/tb_sign_pipe.sv
// Bench for sign_pipe: a saturating and a wrapping instance share one stimulus stream
// and are checked against an integer-arithmetic reference with an in-order queue.
module tb_sign_pipe;

    localparam int DW    = 12;
    localparam int CH    = 4;
    localparam int BUS   = DW * CH;
    localparam int MAXV  = 2**(DW-1) - 1;

    typedef struct {
        logic [BUS-1:0] ds;
        logic [BUS-1:0] dw;
        logic [CH-1:0]  os;
        logic [CH-1:0]  ow;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic [BUS-1:0] data_i;
    logic [1:0]     mode_i;
    logic           valid_i;
    logic           ready_i;

    logic           ready_o_s, valid_o_s, ready_o_w, valid_o_w;
    logic [BUS-1:0] data_o_s, data_o_w;
    logic [CH-1:0]  ovf_o_s, ovf_o_w;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    bit   in_fire, out_fire, rdy_seen;
    bit   hold_chk = 1'b0;
    logic [BUS-1:0] held_data;
    logic [CH-1:0]  held_ovf;
    int   out_cnt = 0;

    always #5 clk = ~clk;

    sign_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH), .SATURATE(1'b1)) dut_s (
        .clk_i(clk), .rstn_i(rstn), .data_i(data_i), .mode_i(mode_i), .valid_i(valid_i),
        .ready_o(ready_o_s), .data_o(data_o_s), .ovf_o(ovf_o_s), .valid_o(valid_o_s),
        .ready_i(ready_i)
    );

    sign_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH), .SATURATE(1'b0)) dut_w (
        .clk_i(clk), .rstn_i(rstn), .data_i(data_i), .mode_i(mode_i), .valid_i(valid_i),
        .ready_o(ready_o_w), .data_o(data_o_w), .ovf_o(ovf_o_w), .valid_o(valid_o_w),
        .ready_i(ready_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_ref(input logic [DW-1:0] xb, input logic [1:0] m,
                                               input bit sat, output bit o);
        int x, r;
        x = (int'(xb) > MAXV) ? int'(xb) - 2**DW : int'(xb);
        case (m)
            2'd0:    r = x;
            2'd1:    r = -x;
            2'd2:    r = (x < 0) ? -x : x;
            default: r = (x > 0) ? -x : x;
        endcase
        o = (r > MAXV);
        if (o && sat) r = MAXV;
        return r[DW-1:0];
    endfunction

    function automatic exp_t model(input logic [BUS-1:0] d, input logic [1:0] m);
        exp_t e;
        bit   o;
        for (int k = 0; k < CH; k++) begin
            e.ds[k*DW +: DW] = lane_ref(d[k*DW +: DW], m, 1'b1, o);
            e.os[k] = o;
            e.dw[k*DW +: DW] = lane_ref(d[k*DW +: DW], m, 1'b0, o);
            e.ow[k] = o;
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 12'h800;
            1:       return 12'h7FF;
            2:       return 12'h000;
            3:       return 12'h001;
            4:       return 12'hFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [BUS-1:0] rand_bus();
        logic [BUS-1:0] b;
        for (int k = 0; k < CH; k++) b[k*DW +: DW] = rand_word();
        return b;
    endfunction

    // Inputs are driven just after an edge; sampling happens 1ns later, then one edge passes.
    task automatic step();
        exp_t e;
        #1;
        in_fire  = valid_i && ready_o_s;
        out_fire = valid_o_s && ready_i;
        rdy_seen = ready_o_s;
        check("ready_match", ready_o_w, ready_o_s);
        check("valid_match", valid_o_w, valid_o_s);
        if (hold_chk) begin
            check("stall_valid", valid_o_s, 1);
            check("stall_data", data_o_s, held_data);
            check("stall_ovf", ovf_o_s, held_ovf);
        end
        if (out_fire) begin
            out_cnt++;
            if (q.size() == 0) begin
                check("out_unexpected", valid_o_s, 0);
            end else begin
                e = q.pop_front();
                check("data_sat", data_o_s, e.ds);
                check("ovf_sat", ovf_o_s, e.os);
                check("data_wrap", data_o_w, e.dw);
                check("ovf_wrap", ovf_o_w, e.ow);
            end
        end
        hold_chk  = valid_o_s && !ready_i;
        held_data = data_o_s;
        held_ovf  = ovf_o_s;
        if (in_fire) q.push_back(model(data_i, mode_i));
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [BUS-1:0] d, input logic [1:0] m,
                            input logic [BUS-1:0] es, input logic [BUS-1:0] ew,
                            input logic [CH-1:0] eo);
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = d;
        mode_i  = m;
        step();
        valid_i = 1'b0;
        data_i  = rand_bus();
        check({tag, "_lat1_valid"}, valid_o_s, 0);
        step();
        check({tag, "_valid"}, valid_o_s, 1);
        check({tag, "_dsat"}, data_o_s, es);
        check({tag, "_dwrap"}, data_o_w, ew);
        check({tag, "_osat"}, ovf_o_s, eo);
        check({tag, "_owrap"}, ovf_o_w, eo);
        step();
    endtask

    logic [BUS-1:0] burst_d[5];
    logic [1:0]     burst_m[5];

    initial begin
        int sent, base;

        rstn    = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        mode_i  = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_o_s, 0);
        check("rst_data", data_o_s, 0);
        check("rst_ovf", ovf_o_s, 0);
        check("rst_ready", ready_o_s, 1);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", ready_o_s, 1);

        send_one("neg", {12'h7FF, 12'h800, 12'h000, 12'h005}, 2'b01,
                 {12'h801, 12'h7FF, 12'h000, 12'hFFB},
                 {12'h801, 12'h800, 12'h000, 12'hFFB}, 4'b0100);
        send_one("abs", {12'h000, 12'hFFF, 12'h001, 12'h800}, 2'b10,
                 {12'h000, 12'h001, 12'h001, 12'h7FF},
                 {12'h000, 12'h001, 12'h001, 12'h800}, 4'b0001);
        send_one("nabs", {12'h7FF, 12'h001, 12'hFFF, 12'h800}, 2'b11,
                 {12'h801, 12'hFFF, 12'hFFF, 12'h800},
                 {12'h801, 12'hFFF, 12'hFFF, 12'h800}, 4'b0000);
        send_one("pass", {12'h800, 12'h7FF, 12'h123, 12'hFFF}, 2'b00,
                 {12'h800, 12'h7FF, 12'h123, 12'hFFF},
                 {12'h800, 12'h7FF, 12'h123, 12'hFFF}, 4'b0000);

        for (int i = 0; i < 5; i++) begin
            burst_d[i] = rand_bus();
            burst_d[i][DW-1:0] = (i % 2 == 0) ? 12'h800 : 12'h7FF;
            burst_m[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
        end
        sent = 0;
        base = out_cnt;
        for (int c = 0; c < 40 && (sent < 5 || q.size() > 0); c++) begin
            ready_i = !(c >= 2 && c <= 4);
            valid_i = (sent < 5);
            if (sent < 5) begin
                data_i = burst_d[sent];
                mode_i = burst_m[sent];
            end
            step();
            if (in_fire) sent++;
            if (c >= 2 && c <= 4) check("burst_ready_low", rdy_seen, 0);
        end
        valid_i = 1'b0;
        check("burst_sent", sent, 5);
        check("burst_out", out_cnt - base, 5);
        check("burst_queue", q.size(), 0);

        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_i = rand_bus();
            mode_i = 2'($urandom_range(0, 3));
            step();
            check("mid_accept", in_fire, 1);
        end
        valid_i = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_valid_s", valid_o_s, 0);
        check("mid_rst_valid_w", valid_o_w, 0);
        check("mid_rst_ready", ready_o_s, 1);
        check("mid_rst_data", data_o_s, 0);
        q.delete();
        hold_chk = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_mid_rst_valid", valid_o_s, 0);
        end

        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            data_i  = rand_bus();
            mode_i  = 2'($urandom_range(0, 3));
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) step();
        check("drain_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
